// File: rtl/corr_phase_picker.sv
// corr_phase_picker: windowed per-phase hit counting, best-phase selection, valid/ack result handshake
module corr_phase_picker #(
    parameter int N_PH     = 8,
    parameter int PH_W     = 3,
    parameter int CNT_W    = 16,
    parameter int WIN_LOG2 = 20,
    parameter int MIN_HITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_PH-1:0]  rdy,
    input  logic             ack,
    output logic             valid,
    output logic [PH_W-1:0]  best_phase,
    output logic [CNT_W-1:0] best_count,
    output logic             lock,
    output logic             overrun
);
    typedef enum logic [1:0] {COUNT, SCAN, PRESENT} state_t;
    state_t state, state_nx;
    logic [N_PH-1:0] rdy_q, hit;
    logic [CNT_W-1:0] live [N_PH];
    logic [CNT_W-1:0] shadow [N_PH];
    logic [CNT_W-1:0] inc [N_PH];
    logic [WIN_LOG2-1:0] win_ctr;
    logic [PH_W-1:0] idx, bidx, nbi;
    logic [CNT_W-1:0] best, nb;
    logic win_end, load;

    assign hit     = rdy & ~rdy_q;
    assign win_end = &win_ctr;

    // saturating next value of each live counter including this cycle's hit
    always_comb begin
        for (int j = 0; j < N_PH; j++)
            inc[j] = (hit[j] && !(&live[j])) ? live[j] + 1'b1 : live[j];
    end

    // scan compare (strictly greater keeps ties on the lowest index) and next state
    always_comb begin
        nb       = (shadow[idx] > best) ? shadow[idx] : best;
        nbi      = (shadow[idx] > best) ? idx : bidx;
        load     = (state == SCAN) && (idx == PH_W'(N_PH - 1));
        state_nx = (state == COUNT && win_end) ? SCAN :
                   load ? PRESENT :
                   (state == PRESENT) ? COUNT : state;
    end

    // edge history, window counter, live counters and end-of-window snapshot
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdy_q   <= '0;
            win_ctr <= '0;
            for (int j = 0; j < N_PH; j++) begin
                live[j]   <= '0;
                shadow[j] <= '0;
            end
        end else begin
            rdy_q   <= rdy;
            win_ctr <= win_ctr + 1'b1;
            for (int j = 0; j < N_PH; j++) begin
                live[j] <= win_end ? '0 : inc[j];
                if (win_end)
                    shadow[j] <= inc[j];
            end
        end
    end

    // FSM state register and scan accumulators (cleared outside SCAN)
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= COUNT;
            idx   <= '0;
            best  <= '0;
            bidx  <= '0;
        end else begin
            state <= state_nx;
            idx   <= (state == SCAN) ? idx + 1'b1 : '0;
            best  <= (state == SCAN) ? nb : '0;
            bidx  <= (state == SCAN) ? nbi : '0;
        end
    end

    // result registers: load as PRESENT is entered so valid rises N_PH+1 cycles after the window end
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid      <= 1'b0;
            best_phase <= '0;
            best_count <= '0;
            lock       <= 1'b0;
            overrun    <= 1'b0;
        end else if (load) begin
            valid      <= 1'b1;
            best_phase <= nbi;
            best_count <= nb;
            lock       <= nb >= CNT_W'(MIN_HITS);
            overrun    <= valid && !ack;
        end else if (valid && ack) begin
            valid   <= 1'b0;
            overrun <= 1'b0;
        end
    end
endmodule

// File: tb/tb_corr_phase_picker.sv
// tb_corr_phase_picker: scoreboard bench driving per-cycle rdy/ack patterns against a cycle model
module tb_corr_phase_picker;
    localparam int N_PH = 8, PH_W = 3, CNT_W = 4, WIN_LOG2 = 6, MIN_HITS = 4;
    localparam int WIN = 64, SAT = 15;

    typedef struct {int ph; int cnt; int lk;} res_t;
    typedef int cnt_t [N_PH];

    logic clk = 1'b0, rst = 1'b0, ack = 1'b0;
    logic [N_PH-1:0] rdy = '0;
    logic valid, lock, overrun;
    logic [PH_W-1:0] best_phase;
    logic [CNT_W-1:0] best_count;

    res_t sbq[$];
    int n_vec = 0, n_bad = 0;
    int c = 0, load_c = -100;
    int live [N_PH];
    logic [N_PH-1:0] rdy_p = '0;
    logic exp_v = 1'b0, exp_o = 1'b0, armed = 1'b0, rst_chk = 1'b0, held_chk = 1'b0;
    int last_ph = 0, last_cnt = 0, last_lk = 0;

    always #5 clk = ~clk;

    corr_phase_picker #(.N_PH(N_PH), .PH_W(PH_W), .CNT_W(CNT_W), .WIN_LOG2(WIN_LOG2), .MIN_HITS(MIN_HITS)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .ack(ack), .valid(valid),
        .best_phase(best_phase), .best_count(best_count), .lock(lock), .overrun(overrun)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, c, got, exp);
        end
    endtask

    // one clock cycle: compare outputs for this cycle, drive inputs, advance the model
    task automatic step(input logic r_n, input logic [N_PH-1:0] r, input logic a);
        res_t e;
        int bc, bi;
        @(negedge clk);
        if (armed) begin
            check("valid", 32'(valid), 32'(exp_v));
            check("overrun", 32'(overrun), 32'(exp_o));
            if (rst_chk) begin
                check("rst_phase", 32'(best_phase), 0);
                check("rst_count", 32'(best_count), 0);
                check("rst_lock", 32'(lock), 0);
            end
            if (c == load_c + 1 && sbq.size() > 0) begin
                e = sbq.pop_front();
                check("phase", 32'(best_phase), e.ph);
                check("count", 32'(best_count), e.cnt);
                check("lock", 32'(lock), e.lk);
                last_ph = e.ph; last_cnt = e.cnt; last_lk = e.lk;
            end else if (held_chk) begin
                check("held_phase", 32'(best_phase), last_ph);
                check("held_count", 32'(best_count), last_cnt);
                check("held_lock", 32'(lock), last_lk);
            end
        end
        rst = r_n; rdy = r; ack = a;
        held_chk = 1'b0;
        if (!r_n) begin
            c = 0; load_c = -100; rdy_p = '0; exp_v = 1'b0; exp_o = 1'b0;
            for (int j = 0; j < N_PH; j++) live[j] = 0;
            sbq.delete();
            last_ph = 0; last_cnt = 0; last_lk = 0;
            rst_chk = 1'b1; armed = 1'b1;
        end else begin
            rst_chk = 1'b0;
            for (int j = 0; j < N_PH; j++)
                if (r[j] && !rdy_p[j] && live[j] < SAT) live[j]++;
            rdy_p = r;
            if (c % WIN == WIN - 1) begin
                bc = 0; bi = 0;
                for (int j = 0; j < N_PH; j++)
                    if (live[j] > bc) begin bc = live[j]; bi = j; end
                e.ph = bi; e.cnt = bc; e.lk = (bc >= MIN_HITS) ? 1 : 0;
                sbq.push_back(e);
                load_c = c + N_PH;
                for (int j = 0; j < N_PH; j++) live[j] = 0;
            end
            if (c == load_c) begin
                exp_o = exp_v && !a;
                exp_v = 1'b1;
            end else if (exp_v && a) begin
                exp_v = 1'b0; exp_o = 1'b0; held_chk = 1'b1;
            end
            c++;
        end
    endtask

    // one full window: cnt[j] single-cycle pulses on odd offsets counting back from the wrap cycle
    task automatic run_win(input cnt_t cnt, input logic [N_PH-1:0] hold, input int ack_off);
        logic [N_PH-1:0] r;
        for (int o = 0; o < WIN; o++) begin
            r = hold;
            for (int j = 0; j < N_PH; j++)
                if (o % 2 == 1 && (WIN - 1 - o) / 2 < cnt[j]) r[j] = 1'b1;
            step(1'b1, r, o == ack_off);
        end
    endtask

    initial begin
        repeat (5) step(1'b0, 8'hFF, 1'b0);
        run_win('{0,0,0,0,0,0,0,0}, 8'hFF, -1);
        run_win('{0,2,0,0,0,0,5,0}, 8'h00, 20);
        run_win('{0,0,3,0,0,3,0,0}, 8'h00, 20);
        run_win('{0,0,0,20,0,0,0,0}, 8'h00, 20);
        run_win('{0,0,0,0,0,0,0,0}, 8'h10, -1);
        run_win('{0,0,0,0,0,0,0,6}, 8'h00, 7);
        run_win('{0,4,0,0,0,0,0,0}, 8'h00, -1);
        run_win('{0,0,0,0,0,0,0,0}, 8'h00, -1);
        run_win('{0,0,0,0,0,0,0,0}, 8'h00, 20);
        run_win('{0,0,0,0,0,0,0,0}, 8'h00, 20);
        repeat (3) step(1'b1, 8'h00, 1'b0);
        repeat (2) step(1'b0, 8'h00, 1'b0);
        run_win('{0,0,0,0,0,2,0,0}, 8'h00, -1);
        repeat (12) step(1'b1, 8'h00, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
